// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the 8-way
// round-robin / fixed-priority arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/pri_pick8.sv
// Combinational winner picker: rotate the candidates so the preferred
// requester sits at the top bit, priority-encode, then un-rotate.
module pri_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [IDX_W-1:0]   w_base;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_pos;

  // Rotation base = last winner, so it lands on bit 0 (searched last) and
  // last_idx-1 lands on bit 7 (searched first). Fixed mode uses base 0.
  assign w_base = rr_mode ? start_idx : '0;
  assign w_dbl  = {cand, cand};
  assign w_rot  = w_dbl[w_base +: N_REQ];

  // NOTE: combinational block assigns a default before the loop, so no
  // path leaves w_pos unassigned and no latch is inferred.
  always_comb begin
    w_pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_rot[k]) w_pos = IDX_W'(k);
    end
  end

  assign win_idx   = w_pos + w_base;
  assign win_valid = |cand;

endmodule

// File: rtl/rr_priority_arbiter8.sv
// 8-requester arbiter: grant FSM, hold timer and round-robin pointer
// around the pri_pick8 encoder. Grants are registered and held until release.
module rr_priority_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rr_mode,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_e        r_state,     w_state_nxt;
  logic [N_REQ-1:0]  r_gnt,       w_gnt_nxt;
  logic [IDX_W-1:0]  r_gnt_idx,   w_gnt_idx_nxt;
  logic              r_gnt_valid, w_gnt_valid_nxt;
  logic [IDX_W-1:0]  r_last_idx,  w_last_idx_nxt;
  logic [HOLD_W-1:0] r_hold_cnt,  w_hold_cnt_nxt;

  logic [N_REQ-1:0]  w_others;
  logic              w_owner_req;
  logic              w_timeout;
  logic              w_take_new;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_win_valid;

  // r_gnt is zero in IDLE, so the same candidate vector serves both states.
  assign w_others    = req & ~r_gnt;
  assign w_owner_req = req[r_gnt_idx];
  assign w_timeout   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  pri_pick8 u_pick (
    .cand      (w_others),
    .start_idx (r_last_idx),
    .rr_mode   (rr_mode),
    .win_idx   (w_win_idx),
    .win_valid (w_win_valid)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_last_idx_nxt  = r_last_idx;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_take_new      = 1'b0;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_win_valid) w_take_new = 1'b1;
      end
      ARB_GRANT: begin
        // Release is checked first, so release wins over a coincident timeout.
        if (!w_owner_req) begin
          if (w_win_valid) begin
            w_take_new = 1'b1;
          end else begin
            w_state_nxt     = ARB_IDLE;
            w_gnt_nxt       = '0;
            w_gnt_idx_nxt   = '0;
            w_gnt_valid_nxt = 1'b0;
            w_hold_cnt_nxt  = '0;
          end
        end else if (w_timeout) begin
          if (w_win_valid) w_take_new = 1'b1;
          else             w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt != '1) begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: ;
    endcase

    if (w_take_new) begin
      w_state_nxt     = ARB_GRANT;
      w_gnt_nxt       = idx_to_onehot(w_win_idx);
      w_gnt_idx_nxt   = w_win_idx;
      w_gnt_valid_nxt = 1'b1;
      w_last_idx_nxt  = w_win_idx;
      w_hold_cnt_nxt  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_last_idx  <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_priority_arbiter8.sv
// Self-checking bench for rr_priority_arbiter8: vector table, directed
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_rr_priority_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rr_mode;

  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Three instances share the stimulus: MAX_HOLD = 4, default 16, and 0 (no timeout).
  rr_priority_arbiter8 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a));
  rr_priority_arbiter8 dut_b (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b));
  rr_priority_arbiter8 #(.MAX_HOLD(0)) dut_c (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c));

  logic [11:0] obs [3];
  assign obs[0] = {gnt_a, idx_a, val_a};
  assign obs[1] = {gnt_b, idx_b, val_b};
  assign obs[2] = {gnt_c, idx_c, val_c};

  // Reference model: owner (-1 = none), cycles already held, last winner.
  int m_owner [3];
  int m_hold  [3];
  int m_last  [3];

  function automatic int max_hold(input int n);
    case (n)
      0:       return 4;
      1:       return 16;
      default: return 0;
    endcase
  endfunction

  // Walk the search order literally: fixed = 7..0, RR = last-1, last-2, ..., last.
  function automatic int pick(input logic [7:0] c, input logic rr, input int last);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = rr ? (last - k + 8) % 8 : 8 - k;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] others;
      int         w;
      if (rst) begin
        m_owner[n] = -1; m_hold[n] = 0; m_last[n] = 0;
      end else if (m_owner[n] < 0) begin
        w = pick(req, rr_mode, m_last[n]);
        if (w >= 0) begin m_owner[n] = w; m_last[n] = w; m_hold[n] = 0; end
      end else begin
        others = req & ~(8'd1 << m_owner[n]);
        w = pick(others, rr_mode, m_last[n]);
        if (!req[m_owner[n]]) begin
          if (w >= 0) begin m_owner[n] = w; m_last[n] = w; end
          else m_owner[n] = -1;
          m_hold[n] = 0;
        end else if (max_hold(n) != 0 && m_hold[n] == max_hold(n) - 1) begin
          if (w >= 0) begin m_owner[n] = w; m_last[n] = w; end
          m_hold[n] = 0;
        end else begin
          m_hold[n] = m_hold[n] + 1;
        end
      end
    end
  endtask

  function automatic logic [11:0] model_obs(input int n);
    if (m_owner[n] < 0) return 12'h000;
    return {8'd1 << m_owner[n], 3'(m_owner[n]), 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    for (int n = 0; n < 3; n++)
      check($sformatf("%s model dut%0d", tag, n), 32'(obs[n]), 32'(model_obs(n)));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rr;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
  } vec_t;

  vec_t tbl [22];

  int exp_rr [9];
  int exp_to [10];

  initial begin
    for (int n = 0; n < 3; n++) begin m_owner[n] = -1; m_hold[n] = 0; m_last[n] = 0; end
    rst = 1'b1; req = 8'h00; rr_mode = 1'b0;

    //            rst  req    rr   gnt    idx  v
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[2]  = '{1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[3]  = '{1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1};
    tbl[6]  = '{1'b0, 8'h50, 1'b0, 8'h10, 3'd4, 1'b1};
    tbl[7]  = '{1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1};
    tbl[8]  = '{1'b1, 8'h40, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[9]  = '{1'b0, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[10] = '{1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[11] = '{1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[12] = '{1'b0, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[13] = '{1'b0, 8'hC0, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[14] = '{1'b0, 8'h60, 1'b1, 8'h40, 3'd6, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[16] = '{1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1};
    tbl[17] = '{1'b0, 8'h22, 1'b1, 8'h02, 3'd1, 1'b1};
    tbl[18] = '{1'b0, 8'h22, 1'b0, 8'h02, 3'd1, 1'b1};
    tbl[19] = '{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[20] = '{1'b0, 8'h0A, 1'b0, 8'h08, 3'd3, 1'b1};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};

    exp_rr = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    exp_to = '{3, 3, 3, 3, 1, 1, 1, 1, 3, 3};

    // Vector table (dut_a, MAX_HOLD = 4; no owner holds long enough to time out).
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; rr_mode = tbl[i].rr;
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d gnt/idx/valid", i), 32'(obs[0]),
            32'({tbl[i].gnt, tbl[i].idx, tbl[i].v}));
    end

    // Round-robin with every requester active; each owner releases after one cycle.
    rst = 1'b1; req = 8'h00; tick("rr_reset"); rst = 1'b0;
    rr_mode = 1'b1; req = 8'hFF;
    tick("rr_first");
    check("rr grant 0", 32'(obs[0]), 32'({8'd1 << exp_rr[0], 3'(exp_rr[0]), 1'b1}));
    for (int i = 1; i < 9; i++) begin
      req = 8'hFF & ~(8'd1 << exp_rr[i-1]);
      tick("rr_seq");
      check($sformatf("rr grant %0d", i), 32'(obs[0]),
            32'({8'd1 << exp_rr[i], 3'(exp_rr[i]), 1'b1}));
    end

    // Timeout switching between two held requesters (MAX_HOLD = 4).
    rst = 1'b1; req = 8'h00; tick("to_reset"); rst = 1'b0;
    rr_mode = 1'b0; req = 8'h0A;
    for (int i = 0; i < 10; i++) begin
      tick("to_seq");
      check($sformatf("timeout cycle %0d", i), 32'(obs[0]),
            32'({8'd1 << exp_to[i], 3'(exp_to[i]), 1'b1}));
    end

    // Lone requester never loses the grant to its own timeout.
    req = 8'h00; tick("lone_idle");
    req = 8'h08;
    for (int i = 0; i < 20; i++) begin
      tick("lone_seq");
      check($sformatf("lone cycle %0d", i), 32'(obs[0]), 32'({8'h08, 3'd3, 1'b1}));
    end

    // Two requesters held long enough for MAX_HOLD = 16 to expire.
    for (int i = 0; i < 50; i++) begin
      req = 8'h11; rr_mode = 1'(i / 25);
      tick("long_hold");
    end

    // Random traffic; owners tend to keep requesting so holds get long.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) rr_mode = 1'($urandom_range(0, 1));
      req = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      if (m_owner[0] >= 0 && $urandom_range(0, 3) != 0) req = req | (8'd1 << m_owner[0]);
      if (m_owner[1] >= 0 && $urandom_range(0, 3) != 0) req = req | (8'd1 << m_owner[1]);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
